// File: rtl/vip_pkg.sv
// Shared VIP types: RGB565 pixel, timing region enum, colour bars,
// default 640x480 timing and small helpers used by source and sink.
package vip_pkg;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FP,
    REG_SYNC,
    REG_BP
  } region_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam rgb565_t BAR_WHITE   = 16'hFFFF;
  localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
  localparam rgb565_t BAR_CYAN    = 16'h07FF;
  localparam rgb565_t BAR_GREEN   = 16'h07E0;
  localparam rgb565_t BAR_MAGENTA = 16'hF81F;
  localparam rgb565_t BAR_RED     = 16'hF800;
  localparam rgb565_t BAR_BLUE    = 16'h001F;
  localparam rgb565_t BAR_BLACK   = 16'h0000;

  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  function automatic region_e region_of(
    input int cnt,
    input int act,
    input int fp,
    input int sync
  );
    region_e r;
    r = REG_BP;
    unique case (1'b1)
      cnt < act:
        r = REG_ACTIVE;
      cnt >= act && cnt < act + fp:
        r = REG_FP;
      cnt >= act + fp && cnt < act + fp + sync:
        r = REG_SYNC;
      default:
        r = REG_BP;
    endcase
    return r;
  endfunction

  function automatic rgb565_t bar_colour(input logic [2:0] idx);
    rgb565_t c;
    c = BAR_BLACK;
    unique case (idx)
      3'd0: c = BAR_WHITE;
      3'd1: c = BAR_YELLOW;
      3'd2: c = BAR_CYAN;
      3'd3: c = BAR_GREEN;
      3'd4: c = BAR_MAGENTA;
      3'd5: c = BAR_RED;
      3'd6: c = BAR_BLUE;
      3'd7: c = BAR_BLACK;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vip_frame_source_if.sv
// Frame source bundle: show-ahead FIFO read side plus the
// vsync/href/de/RGB565 pixel stream toward the detection chain.
interface vip_frame_source_if;
  import vip_pkg::*;

  rgb565_t pix_data;
  logic    pix_empty;
  logic    pix_rd;

  logic    pre_frame_vsync;
  logic    pre_frame_hsync;
  logic    pre_frame_de;
  rgb565_t pre_rgb;

  modport master (
    input  pix_data,
    input  pix_empty,
    output pix_rd,
    output pre_frame_vsync,
    output pre_frame_hsync,
    output pre_frame_de,
    output pre_rgb
  );

  modport slave (
    output pix_data,
    output pix_empty,
    input  pix_rd,
    input  pre_frame_vsync,
    input  pre_frame_hsync,
    input  pre_frame_de,
    input  pre_rgb
  );

endinterface

// File: rtl/vip_timing_counter.sv
// Raster h/v counters with region decode; shared by the frame
// source and the sink-side timing checker.
module vip_timing_counter
  import vip_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HW = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output region_e       h_region,
  output region_e       v_region,
  output logic          frame_last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic line_last;

  assign line_last  = h_cnt == H_LAST;
  assign frame_last = line_last && (v_cnt == V_LAST);

  // Counters sit at the frame origin whenever the source is stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_last) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST)
        v_cnt <= '0;
      else
        v_cnt <= v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    h_region = region_of(int'(h_cnt), H_ACTIVE, H_FP, H_SYNC);
    v_region = region_of(int'(v_cnt), V_ACTIVE, V_FP, V_SYNC);
  end

endmodule

// File: rtl/vip_frame_source.sv
// Transmit-side VIP timing and pixel source with FIFO underflow fill.
// Optional colour-bar generator: define VIP_FRAME_SOURCE_PATTERN_EN.
module vip_frame_source
  import vip_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
`ifdef VIP_FRAME_SOURCE_PATTERN_EN
  input  logic        pattern_sel,
`endif
  vip_frame_source_if.master vif,
  output logic        frame_start,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam int HW = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e        state;
  logic          run;
  logic          frame_last;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  region_e       h_region;
  region_e       v_region;
  logic          active;
  logic          v_sync;
  logic          pat_on;
  logic          uf_evt;
  rgb565_t       pix_sel;
  logic [15:0]   run_cnt;

  assign run = state == RUN;

  vip_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_tc (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .h_region   (h_region),
    .v_region   (v_region),
    .frame_last (frame_last)
  );

  assign active = run
                & (h_region == REG_ACTIVE)
                & (v_region == REG_ACTIVE);

  assign v_sync = run & (v_region == REG_SYNC);

  assign frame_start = run
                     && (h_cnt == '0)
                     && (v_cnt == '0);

`ifdef VIP_FRAME_SOURCE_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic       pat_q;
  logic [2:0] bar_idx;

  // The first pixel is fetched in the frame_start cycle itself, so the
  // live select applies there and the latched copy for the rest.
  assign pat_on  = frame_start ? pattern_sel : pat_q;
  assign bar_idx = 3'(h_cnt / HW'(BAR_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pat_q <= 1'b0;
    else if (frame_start)
      pat_q <= pattern_sel;
  end

  assign pix_sel = pat_on ? bar_colour(bar_idx)
                 : (vif.pix_empty ? BAR_BLACK : vif.pix_data);
`else
  assign pat_on  = 1'b0;
  assign pix_sel = vif.pix_empty ? BAR_BLACK : vif.pix_data;
`endif

  assign vif.pix_rd = active & ~vif.pix_empty & ~pat_on;
  assign uf_evt     = active &  vif.pix_empty & ~pat_on;

  // Run/idle control plus the registered stream stage, one clock
  // behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      vif.pre_frame_hsync <= 1'b0;
      vif.pre_frame_de    <= 1'b0;
      vif.pre_frame_vsync <= 1'b0;
      vif.pre_rgb         <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (en)
            state <= RUN;
        RUN:
          if (frame_last && !en)
            state <= IDLE;
        default:
          state <= IDLE;
      endcase
      vif.pre_frame_hsync <= active;
      vif.pre_frame_de    <= active;
      vif.pre_frame_vsync <= v_sync;
      vif.pre_rgb         <= active ? pix_sel : '0;
    end
  end

  // A miss landing on frame_start belongs to the frame just opening.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
      run_cnt       <= '0;
    end else if (frame_start) begin
      underflow_cnt <= run_cnt;
      run_cnt       <= {15'd0, uf_evt};
      underflow     <= uf_evt;
    end else if (uf_evt) begin
      underflow <= 1'b1;
      if (run_cnt != 16'hFFFF)
        run_cnt <= run_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vip_frame_source.sv
// Randomized bench for vip_frame_source against a raster-position
// model on a small 7x6 timing.
module tb_vip_frame_source;

  localparam int HA = 4, HF = 1, HS = 1, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        frame_start;
  logic        underflow;
  logic [15:0] underflow_cnt;
`ifdef VIP_FRAME_SOURCE_PATTERN_EN
  logic        pattern_sel;
`endif

  vip_frame_source_if vif ();

  vip_frame_source #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
`ifdef VIP_FRAME_SOURCE_PATTERN_EN
    .pattern_sel   (pattern_sel),
`endif
    .vif           (vif),
    .frame_start   (frame_start),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: frame position p in 0..FT-1 plus expected registered outputs
  bit          m_run;
  int          m_p;
  bit          m_hs, m_de, m_vs, m_uf;
  logic [15:0] m_rgb;
  int          m_run_cnt, m_ufcnt;

  logic [15:0] fifo[$];
  logic [15:0] got[$];
  logic [15:0] nxt;
  bit          force_empty, auto_fill, collect;
  int          cyc, last_fs, pops, vsc, f_pops, f_vs, f_period;

  task automatic model_reset();
    m_run = 0; m_p = 0;
    m_hs = 0; m_de = 0; m_vs = 0; m_uf = 0;
    m_rgb = 16'h0; m_run_cnt = 0; m_ufcnt = 0;
    last_fs = -1; pops = 0; vsc = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_rd"}, vif.pix_rd, 0);
    chk({tag, "_hs"}, vif.pre_frame_hsync, 0);
    chk({tag, "_de"}, vif.pre_frame_de, 0);
    chk({tag, "_vs"}, vif.pre_frame_vsync, 0);
    chk({tag, "_rgb"}, vif.pre_rgb, 0);
    chk({tag, "_uf"}, underflow, 0);
    chk({tag, "_ufcnt"}, underflow_cnt, 0);
  endtask

  // Called at a negedge; drives FIFO head, checks, advances one clock.
  task automatic step();
    bit          act, emp, vsn, fs, ev;
    int          h, v;
    logic [15:0] dat;
    emp = force_empty || (fifo.size() == 0);
    dat = (fifo.size() != 0) ? fifo[0] : 16'($urandom);
    vif.pix_empty = emp;
    vif.pix_data  = dat;
    #1;
    h   = m_p % HT;
    v   = m_p / HT;
    act = m_run && h < HA && v < VA;
    vsn = m_run && v >= VA + VF && v < VA + VF + VS;
    fs  = m_run && m_p == 0;
    chk("frame_start", frame_start, fs);
    chk("pix_rd", vif.pix_rd, act && !emp);
    chk("hsync", vif.pre_frame_hsync, m_hs);
    chk("de", vif.pre_frame_de, m_de);
    chk("vsync", vif.pre_frame_vsync, m_vs);
    chk("rgb", vif.pre_rgb, m_rgb);
    chk("underflow", underflow, m_uf);
    chk("underflow_cnt", underflow_cnt, m_ufcnt);
    if (frame_start) begin
      if (last_fs >= 0) f_period = cyc - last_fs;
      last_fs = cyc;
      f_pops = pops; f_vs = vsc;
      pops = 0; vsc = 0;
    end
    if (vif.pix_rd) pops++;
    if (vif.pre_frame_vsync) vsc++;
    if (collect && vif.pre_frame_de) got.push_back(vif.pre_rgb);
    m_hs  = act;
    m_de  = act;
    m_vs  = vsn;
    m_rgb = act ? (emp ? 16'h0 : dat) : 16'h0;
    ev = act && emp;
    if (fs) begin
      m_ufcnt = m_run_cnt; m_run_cnt = ev ? 1 : 0; m_uf = ev;
    end else if (ev) begin
      m_uf = 1;
      if (m_run_cnt < 65535) m_run_cnt++;
    end
    if (act && !emp) void'(fifo.pop_front());
    if (!m_run) begin
      if (en) m_run = 1;
    end else if (m_p == FT - 1) begin
      m_p = 0;
      if (!en) m_run = 0;
    end else begin
      m_p++;
    end
    if (auto_fill)
      while (fifo.size() < 4) begin
        fifo.push_back(nxt);
        nxt++;
      end
    cyc++;
    @(negedge clk);
  endtask

  task automatic align(input int pos);
    int k;
    k = 0;
    while (!(m_run && m_p == pos) && k < 200) begin
      step();
      k++;
    end
    if (!(m_run && m_p == pos)) chk("align_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0;
    force_empty = 0; auto_fill = 0; collect = 0;
    nxt = 16'd13; cyc = 0; f_pops = 0; f_vs = 0; f_period = 0;
    vif.pix_data = 16'h0; vif.pix_empty = 1'b1;
`ifdef VIP_FRAME_SOURCE_PATTERN_EN
    pattern_sel = 1'b0;
`endif
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_idle("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();

    // Preloaded FIFO streams out in raster order
    for (int i = 1; i <= 12; i++) fifo.push_back(16'(i));
    en = 1'b1; collect = 1;
    for (int i = 0; i < 43; i++) begin
      if (i == 30) auto_fill = 1;
      step();
    end
    collect = 0;
    chk("seq_len", got.size(), 12);
    for (int i = 0; i < 12 && i < got.size(); i++)
      chk($sformatf("seq%0d", i), got[i], i + 1);

    // Frame-level counts with a full FIFO
    repeat (2 * FT) step();
    chk("pops_per_frame", f_pops, VA * HA);
    chk("vsync_clocks", f_vs, VS * HT);
    chk("frame_period", f_period, FT);

    // Three forced underflow pixels
    align(0);
    for (int i = 0; i < FT; i++) begin
      force_empty = (i == 1 || i == 2 || i == 8);
      step();
      if (i == 1 || i == 2) begin
        chk("uf_pix_de", vif.pre_frame_de, 1);
        chk("uf_pix_rgb", vif.pre_rgb, 0);
      end
    end
    force_empty = 0;
    chk("uf_sticky", underflow, 1);
    step();
    chk("uf_cnt", underflow_cnt, 3);
    chk("uf_clear", underflow, 0);

    // en dropped mid-frame: frame completes then idles
    repeat (10) step();
    en = 1'b0;
    for (int k = 0; k < 100 && m_run; k++) step();
    if (m_run) chk("idle_timeout", 0, 1);
    repeat (3) step();
    chk("idle_de", vif.pre_frame_de, 0);
    chk("idle_hs", vif.pre_frame_hsync, 0);
    chk("idle_vs", vif.pre_frame_vsync, 0);
    chk("idle_rgb", vif.pre_rgb, 0);
    chk("idle_fs", frame_start, 0);
    en = 1'b1;
    step();
    chk("fs_reenable", frame_start, 1);

    // Random enable and FIFO starvation
    for (int i = 0; i < 800; i++) begin
      force_empty = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) en = ~en;
      step();
    end
    en = 1'b1; force_empty = 0;

    // Asynchronous reset in the middle of a line
    align(3);
    #2 rst_n = 1'b0;
    #1 chk_idle("mrst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("fs_after_rst", frame_start, 1);
    repeat (50) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
